pe_mac_sequencer: RTL and testbench
===================================

Name: pe_mac_sequencer

Overview:
- Sequences one PE (FP16 multiply-accumulate datapath) through a dot product of programmable length K.
- Reads operand pairs from external weight and input SRAMs, which have a 1-cycle read latency, and drives the PE's InnerAccum_ctr and i_psum.
- Captures the PE result in the single cycle it is valid and reports completion with a one-cycle done pulse.
- Sits between the layer-level scheduler (start, length, base addresses, bias) and one PE plus its operand memories.

Parameters:
- ADDR_W, 10, width of the weight and input SRAM addresses.
- LEN_W, 8, width of the dot-product length field (K up to 2^LEN_W - 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- i_start  input  1  request a new dot product; sampled only in IDLE.
- i_len  input  LEN_W  K, the number of MAC operations; sampled with i_start.
- i_wbase  input  ADDR_W  weight SRAM base address; sampled with i_start.
- i_ibase  input  ADDR_W  input SRAM base address; sampled with i_start.
- i_bias  input  16  FP16 initial partial sum; sampled with i_start.
- i_pe_result  input  16  PE o_result.
- o_rd_en  output  1  read enable to both SRAMs.
- o_waddr  output  ADDR_W  weight SRAM address.
- o_iaddr  output  ADDR_W  input SRAM address.
- o_pe_accum  output  1  drives PE InnerAccum_ctr.
- o_pe_psum  output  16  drives PE i_psum.
- o_busy  output  1  high from the cycle after start acceptance through the DONE state.
- o_done  output  1  one-cycle pulse; o_result is valid in this cycle.
- o_result  output  16  captured FP16 dot-product result; holds until the next capture.

Behaviour:
- Reset values, with rst low at any time, including mid-operation:
  - State = IDLE.
  - All outputs 0: o_rd_en, o_waddr, o_iaddr, o_pe_accum, o_pe_psum, o_busy, o_done, o_result.
  - Element counter = 0 and all latched fields = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - If i_start = 1 and i_len != 0: latch len, wbase, ibase and bias, then go to RUN.
  - If i_start = 1 and i_len = 0: ignore the request and stay in IDLE (no done pulse).
- RUN, lasting exactly K cycles, with cycle k = 0..K-1:
  - o_rd_en = 1, o_waddr = wbase + k, o_iaddr = ibase + k.
  - Address arithmetic is modulo 2^ADDR_W; it wraps silently.
  - After cycle K-1, go to DRAIN.
- Operand alignment:
  - SRAM data for element k reaches the PE in cycle k+1.
  - o_pe_accum and o_pe_psum are registered so they are valid in that same cycle k+1.
  - o_pe_accum = 0 for element 0, so the PE adds i_psum = bias. It is 1 for elements 1..K-1, so the PE adds its own output.
  - o_pe_psum = latched bias from the first RUN cycle until IDLE is re-entered; it then returns to 0.
- PE latency:
  - Operands arriving in cycle c contribute to i_pe_result visible in cycle c+2.
  - The result including element K-1 is therefore visible exactly in cycle K+2, counted from RUN cycle 0.
  - The PE re-adds its multiplier register every cycle, so i_pe_result is valid only in that one cycle.
- DRAIN:
  - Lasts 3 cycles, with o_rd_en = 0.
  - On the clock edge ending the 3rd DRAIN cycle (cycle K+2), o_result <= i_pe_result; then go to DONE.
- DONE:
  - Lasts 1 cycle, with o_done = 1 and o_busy = 1; then go to IDLE.
- While in RUN, DRAIN or DONE:
  - i_start is ignored.
  - Inputs i_len, i_wbase, i_ibase and i_bias may change freely.
- Back-to-back operation: a new start can be accepted in the first IDLE cycle after DONE. Minimum job period is therefore K+5 cycles.
- o_busy timing: rises in RUN cycle 0 and falls in the first IDLE cycle.
- The block performs no FP16 arithmetic and does not interpret bias or result values.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with i_start = 1 → all outputs 0, state IDLE; after release with i_start held, RUN starts on the next edge.
- K=4, bias=16'h0000, weights all 16'h3C00 (1.0), inputs all 16'h4000 (2.0), wbase=0, ibase=16 → addresses 0..3 / 16..19 with o_rd_en high for 4 cycles; o_pe_accum = 0,1,1,1 aligned with the data; o_done 3+1 cycles after the last read; o_result = 16'h4800 (8.0).
- K=1, bias=16'h3C00, w=16'h4000, x=16'h4200 (3.0) → o_result = 16'h4700 (7.0); o_done asserted in cycle 4 after RUN cycle 0.
- Wrap-around: wbase=10'h3FE, K=4 → o_waddr = 3FE, 3FF, 000, 001.
- i_start pulsed during RUN and during DONE, and i_len=0 in IDLE → all ignored; no extra o_done; o_busy pattern unchanged.
- Reset asserted mid-RUN (k=2 of 5) → outputs 0 immediately, asynchronously; o_done never fires; a new K=2 job after release completes correctly.

Source files
------------

// File: rtl/pe_mac_sequencer.sv
// rtl/pe_mac_sequencer.sv - sequences one FP16 MAC PE through a K-element dot product
module pe_mac_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [ADDR_W-1:0] i_wbase,
  input  logic [ADDR_W-1:0] i_ibase,
  input  logic [15:0]       i_bias,
  input  logic [15:0]       i_pe_result,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [ADDR_W-1:0] o_iaddr,
  output logic              o_pe_accum,
  output logic [15:0]       o_pe_psum,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Three drain cycles cover the SRAM latency plus the two-stage PE pipeline.
  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(2);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  logic              accum_q, accum_d;
  logic [15:0]       psum_q, psum_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       result_q, result_d;

  // Next-state and next-output computation; every output is registered so it
  // lines up with the cycle the SRAM data reaches the PE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    rd_en_d  = rd_en_q;
    waddr_d  = waddr_q;
    iaddr_d  = iaddr_q;
    accum_d  = accum_q;
    psum_d   = psum_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && (i_len != '0)) begin
          state_d = S_RUN;
          len_d   = i_len;
          cnt_d   = '0;
          rd_en_d = 1'b1;
          waddr_d = i_wbase;
          iaddr_d = i_ibase;
          psum_d  = i_bias;
          accum_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        // Element cnt_q reaches the PE next cycle; only element 0 takes the bias.
        accum_d = (cnt_q != '0);
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          rd_en_d = 1'b0;
          waddr_d = '0;
          iaddr_d = '0;
        end else begin
          cnt_d   = cnt_q + LEN_W'(1);
          waddr_d = waddr_q + ADDR_W'(1);
          iaddr_d = iaddr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        accum_d = 1'b0;
        if (cnt_q == DRAIN_LAST) begin
          // The PE result is valid only in this cycle, so capture it now.
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = i_pe_result;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        psum_d  = '0;
        len_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      rd_en_q  <= 1'b0;
      waddr_q  <= '0;
      iaddr_q  <= '0;
      accum_q  <= 1'b0;
      psum_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rd_en_q  <= rd_en_d;
      waddr_q  <= waddr_d;
      iaddr_q  <= iaddr_d;
      accum_q  <= accum_d;
      psum_q   <= psum_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign o_rd_en    = rd_en_q;
  assign o_waddr    = waddr_q;
  assign o_iaddr    = iaddr_q;
  assign o_pe_accum = accum_q;
  assign o_pe_psum  = psum_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_result   = result_q;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// tb/tb_pe_mac_sequencer.sv - randomized checks of pe_mac_sequencer against SRAM/PE models
module tb_pe_mac_sequencer;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_start = 1'b0;
  logic [LEN_W-1:0]  i_len = '0;
  logic [ADDR_W-1:0] i_wbase = '0;
  logic [ADDR_W-1:0] i_ibase = '0;
  logic [15:0]       i_bias = '0;
  logic [15:0]       i_pe_result;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_waddr;
  logic [ADDR_W-1:0] o_iaddr;
  logic              o_pe_accum;
  logic [15:0]       o_pe_psum;
  logic              o_busy;
  logic              o_done;
  logic [15:0]       o_result;

  int total = 0;
  int bad   = 0;

  logic [15:0] wmem [1024];
  logic [15:0] xmem [1024];
  logic [15:0] w_data = '0;
  logic [15:0] x_data = '0;
  real         prod_r = 0.0;
  real         psum_r = 0.0;
  real         acc_r  = 0.0;
  logic        sel_r  = 1'b0;

  pe_mac_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
    .i_wbase(i_wbase), .i_ibase(i_ibase), .i_bias(i_bias),
    .i_pe_result(i_pe_result), .o_rd_en(o_rd_en), .o_waddr(o_waddr),
    .o_iaddr(o_iaddr), .o_pe_accum(o_pe_accum), .o_pe_psum(o_pe_psum),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
  );

  always #5 clk = ~clk;

  function automatic real fp2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(h[9:0]) / 1024.0;
    while (e > 15) begin v = v * 2.0; e--; end
    while (e < 15) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2fp(input real v);
    real  a;
    int   e;
    int   m;
    logic s;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a == 0.0) return 16'h0000;
    e = 15;
    while (a >= 2.0 && e < 31) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > 0) begin a = a * 2.0; e--; end
    if (e <= 0) return {s, 15'd0};
    if (e >= 31) return {s, 5'h1f, 10'd0};
    m = $rtoi((a - 1.0) * 1024.0);
    return {s, 5'(e), 10'(m)};
  endfunction

  function automatic logic [15:0] rnd_fp();
    return {1'($urandom), 5'(14 + $urandom_range(0, 1)), 10'($urandom)};
  endfunction

  // Reference: bias plus the sum of K products over the addressed SRAM words.
  function automatic logic [15:0] exp_dot(input int k, input logic [9:0] wb,
                                          input logic [9:0] ib, input logic [15:0] bias);
    real       acc;
    logic [9:0] wa;
    logic [9:0] ia;
    acc = fp2r(bias);
    wa  = wb;
    ia  = ib;
    for (int j = 0; j < k; j++) begin
      acc = acc + fp2r(wmem[wa]) * fp2r(xmem[ia]);
      wa  = wa + 10'd1;
      ia  = ia + 10'd1;
    end
    return r2fp(acc);
  endfunction

  // SRAMs with 1-cycle read latency; idle cycles return unrelated words.
  always @(posedge clk) begin
    if (o_rd_en) begin
      w_data <= wmem[o_waddr];
      x_data <= xmem[o_iaddr];
    end else begin
      w_data <= wmem[10'($urandom)];
      x_data <= xmem[10'($urandom)];
    end
  end

  // Two-stage PE: operands in cycle c show up in the result at cycle c+2.
  always @(posedge clk) begin
    prod_r <= fp2r(w_data) * fp2r(x_data);
    sel_r  <= o_pe_accum;
    psum_r <= fp2r(o_pe_psum);
    acc_r  <= (sel_r ? acc_r : psum_r) + prod_r;
  end

  always_comb i_pe_result = r2fp(acc_r);

  // Starts a job at the current negedge and checks every cycle through the first IDLE cycle.
  task automatic run_job(input int k, input logic [9:0] wb, input logic [9:0] ib,
                         input logic [15:0] bias, input bit glitch, input string tag);
    logic [15:0] er;
    logic [9:0]  ew;
    logic [9:0]  ei;
    er = exp_dot(k, wb, ib, bias);
    i_start = 1'b1;
    i_len   = 8'(k);
    i_wbase = wb;
    i_ibase = ib;
    i_bias  = bias;
    @(posedge clk);
    for (int c = 0; c <= k + 4; c++) begin
      @(negedge clk);
      ew = wb + 10'(c);
      ei = ib + 10'(c);
      total++;
      if (o_rd_en !== (c < k)) begin
        bad++; $display("FAIL %s c=%0d rd_en got=%b want=%b", tag, c, o_rd_en, (c < k));
      end
      if (c < k) begin
        total++;
        if (o_waddr !== ew || o_iaddr !== ei) begin
          bad++; $display("FAIL %s c=%0d addr got=%h/%h want=%h/%h", tag, c, o_waddr, o_iaddr, ew, ei);
        end
      end
      if (c >= 1 && c <= k) begin
        total++;
        if (o_pe_accum !== (c >= 2)) begin
          bad++; $display("FAIL %s c=%0d pe_accum got=%b want=%b", tag, c, o_pe_accum, (c >= 2));
        end
      end
      total++;
      if (o_pe_psum !== ((c <= k + 3) ? bias : 16'h0000)) begin
        bad++; $display("FAIL %s c=%0d pe_psum got=%h want=%h", tag, c, o_pe_psum,
                        (c <= k + 3) ? bias : 16'h0000);
      end
      total++;
      if (o_busy !== (c <= k + 3) || o_done !== (c == k + 3)) begin
        bad++; $display("FAIL %s c=%0d busy/done got=%b%b want=%b%b", tag, c, o_busy, o_done,
                        (c <= k + 3), (c == k + 3));
      end
      if (c >= k + 3) begin
        total++;
        if (o_result !== er) begin
          bad++; $display("FAIL %s c=%0d result got=%h want=%h", tag, c, o_result, er);
        end
      end
      i_start = (glitch && c < k + 4) ? 1'b1 : 1'b0;
      if (glitch) begin
        i_len   = 8'($urandom);
        i_wbase = 10'($urandom);
        i_ibase = 10'($urandom);
        i_bias  = 16'($urandom);
      end
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_start = 1'b1;
    i_len   = 8'd3;
    i_wbase = 10'($urandom);
    i_ibase = 10'($urandom);
    i_bias  = rnd_fp();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({o_rd_en, o_waddr, o_iaddr, o_pe_accum, o_pe_psum, o_busy, o_done, o_result} !== 56'd0) begin
        bad++; $display("FAIL reset_hold c=%0d outputs got=%h want=0", c,
                        {o_rd_en, o_waddr, o_iaddr, o_pe_accum, o_pe_psum, o_busy, o_done, o_result});
      end
    end
    rst = 1'b1;
    run_job(3, i_wbase, i_ibase, i_bias, 1'b0, "reset_release");
  endtask

  task automatic test_k4_directed();
    for (int j = 0; j < 4; j++) begin
      wmem[j]      = 16'h3C00;
      xmem[16 + j] = 16'h4000;
    end
    run_job(4, 10'd0, 10'd16, 16'h0000, 1'b0, "k4");
    total++;
    if (o_result !== 16'h4800) begin
      bad++; $display("FAIL k4_value result got=%h want=4800", o_result);
    end
  endtask

  task automatic test_k1_directed();
    wmem[100] = 16'h4000;
    xmem[200] = 16'h4200;
    run_job(1, 10'd100, 10'd200, 16'h3C00, 1'b0, "k1");
    total++;
    if (o_result !== 16'h4700) begin
      bad++; $display("FAIL k1_value result got=%h want=4700", o_result);
    end
  endtask

  task automatic test_wrap();
    run_job(4, 10'h3FE, 10'($urandom), rnd_fp(), 1'b0, "wrap_w");
    run_job(3, 10'($urandom), 10'h3FF, rnd_fp(), 1'b0, "wrap_i");
  endtask

  task automatic test_ignored_starts();
    i_start = 1'b1;
    i_len   = 8'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (o_busy !== 1'b0 || o_rd_en !== 1'b0 || o_done !== 1'b0) begin
        bad++; $display("FAIL len_zero c=%0d busy/rd/done got=%b%b%b want=000", c, o_busy, o_rd_en, o_done);
      end
    end
    run_job(3, 10'($urandom), 10'($urandom), rnd_fp(), 1'b1, "start_glitch");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
        bad++; $display("FAIL after_glitch c=%0d busy/done got=%b%b want=00", c, o_busy, o_done);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] wb;
    wb = 10'($urandom);
    i_start = 1'b1;
    i_len   = 8'd5;
    i_wbase = wb;
    i_ibase = 10'($urandom);
    i_bias  = rnd_fp();
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      total++;
      if (o_waddr !== wb + 10'(c)) begin
        bad++; $display("FAIL mid_run c=%0d waddr got=%h want=%h", c, o_waddr, wb + 10'(c));
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if ({o_rd_en, o_waddr, o_iaddr, o_pe_accum, o_pe_psum, o_busy, o_done, o_result} !== 56'd0) begin
      bad++; $display("FAIL async_reset outputs got=%h want=0",
                      {o_rd_en, o_waddr, o_iaddr, o_pe_accum, o_pe_psum, o_busy, o_done, o_result});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        bad++; $display("FAIL post_reset c=%0d busy/done got=%b%b want=00", c, o_busy, o_done);
      end
    end
    run_job(2, 10'($urandom), 10'($urandom), rnd_fp(), 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 8; n++) begin
      run_job($urandom_range(1, 20), 10'($urandom), 10'($urandom), rnd_fp(),
              1'($urandom), "random");
    end
  endtask

  initial begin
    for (int j = 0; j < 1024; j++) begin
      wmem[j] = rnd_fp();
      xmem[j] = rnd_fp();
    end
    test_reset();
    test_k4_directed();
    test_k1_directed();
    test_wrap();
    test_ignored_starts();
    test_reset_mid_run();
    test_back_to_back_random();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
